// File: rtl/ahbl_exclusive_monitor.sv
`default_nettype none
// ============================================================================
// ahbl_exclusive_monitor
// AHB-Lite exclusive-access monitor with one reservation per master ID.
// Rev 1.0
// ============================================================================
module ahbl_exclusive_monitor #(
    parameter int N_MASTERS    = 2,
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int GRANULE_BITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              src_hready,
    output logic              src_hready_resp,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,
    output logic              src_hexokay,

    output logic              dst_hready,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata
);

    localparam int          W_ID   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int          W_GRAN = W_ADDR - GRANULE_BITS;
    localparam int unsigned N_IDS  = N_MASTERS;

    // Reservation table
    logic [N_MASTERS-1:0] resv_valid_q;
    logic [N_MASTERS-1:0] resv_valid_d;
    logic [W_GRAN-1:0]    resv_addr_q [N_MASTERS];
    logic [W_GRAN-1:0]    resv_addr_d [N_MASTERS];
    logic [N_MASTERS-1:0] resv_hit;

    // Data-phase flags
    logic dph_excl_q, dph_excl_d;
    logic dph_ok_q,   dph_ok_d;
    logic dph_supp_q, dph_supp_d;

    logic              accept;
    logic              id_in_range;
    logic [W_ID-1:0]   id;
    logic [W_GRAN-1:0] granule;
    logic              excl_rd_set;
    logic              excl_wr_pass;
    logic              excl_wr_fail;
    logic              own_hit;

    assign accept      = src_hready & src_htrans[1];
    assign id          = src_hmaster[W_ID-1:0];
    assign id_in_range = ({24'd0, src_hmaster} < N_IDS);
    assign granule     = src_haddr[W_ADDR-1:GRANULE_BITS];

    assign own_hit      = id_in_range & resv_hit[id];
    assign excl_rd_set  = accept & src_hexcl & ~src_hwrite & id_in_range;
    assign excl_wr_pass = accept & src_hexcl & src_hwrite & own_hit;
    assign excl_wr_fail = accept & src_hexcl & src_hwrite & ~own_hit;

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_entry
            logic is_own;
            logic set_e;
            logic clr_e;

            assign resv_hit[gi] = resv_valid_q[gi] & (resv_addr_q[gi] == granule);
            assign is_own       = id_in_range & (id == W_ID'(gi));
            assign set_e        = excl_rd_set & is_own;
            // Successful exclusive or plain writes kill every reservation on the
            // granule; a failed exclusive only drops the writer's own entry.
            assign clr_e        = (accept & src_hwrite & (~src_hexcl | excl_wr_pass) & resv_hit[gi])
                                | (excl_wr_fail & is_own);

            assign resv_valid_d[gi] = set_e ? 1'b1 : (clr_e ? 1'b0 : resv_valid_q[gi]);
            assign resv_addr_d[gi]  = set_e ? granule : resv_addr_q[gi];
        end
    endgenerate

    always_comb begin
        dph_excl_d = dph_excl_q;
        dph_ok_d   = dph_ok_q;
        dph_supp_d = dph_supp_q;
        if (src_hready) begin
            dph_excl_d = accept & src_hexcl;
            dph_ok_d   = excl_rd_set | excl_wr_pass;
            dph_supp_d = excl_wr_fail;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid_q <= '0;
            for (int i = 0; i < N_MASTERS; i++) begin
                resv_addr_q[i] <= '0;
            end
            dph_excl_q <= 1'b0;
            dph_ok_q   <= 1'b0;
            dph_supp_q <= 1'b0;
        end else begin
            resv_valid_q <= resv_valid_d;
            for (int i = 0; i < N_MASTERS; i++) begin
                resv_addr_q[i] <= resv_addr_d[i];
            end
            dph_excl_q <= dph_excl_d;
            dph_ok_q   <= dph_ok_d;
            dph_supp_q <= dph_supp_d;
        end
    end

    assign dst_hready    = src_hready;
    assign dst_haddr     = src_haddr;
    assign dst_hwrite    = src_hwrite;
    assign dst_htrans    = excl_wr_fail ? 2'b00 : src_htrans;
    assign dst_hsize     = src_hsize;
    assign dst_hburst    = src_hburst;
    assign dst_hprot     = src_hprot;
    assign dst_hmastlock = src_hmastlock;
    assign dst_hwdata    = src_hwdata;

    // A suppressed write never reached dst, so the monitor completes it itself.
    assign src_hready_resp = dph_supp_q ? 1'b1 : dst_hready_resp;
    assign src_hresp       = dph_supp_q ? 1'b0 : dst_hresp;
    assign src_hrdata      = dph_supp_q ? '0 : dst_hrdata;
    assign src_hexokay     = dph_excl_q & dph_ok_q & ~src_hresp;

endmodule
`default_nettype wire

// File: doc/ahbl_exclusive_monitor.md
# ahbl_exclusive_monitor

AHB-Lite exclusive-access monitor. It sits between one slave-side port of the busfabric crossbar (`dst_*` of the crossbar) and a memory slave that has no exclusive support of its own. It keeps one address reservation per master ID and suppresses failed exclusive writes. It drives `hexokay` back toward the crossbar so that LR/SC sequences from multiple harts resolve correctly.

## Interface
- `N_MASTERS`, default 2: number of reservation entries; master ID = `src_hmaster[W_ID-1:0]`, W_ID = max(1, $clog2(N_MASTERS)).
- `W_ADDR`, default 32: address width.
- `W_DATA`, default 32: data width.
- `GRANULE_BITS`, default 2: reservation granule = 2^GRANULE_BITS bytes; match on `haddr[W_ADDR-1:GRANULE_BITS]`.
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `src_hready` in 1: bus HREADY from the crossbar.
- `src_hready_resp` out 1: HREADYOUT to the crossbar.
- `src_hresp` out 1: response to the crossbar.
- `src_haddr` in W_ADDR, `src_hwrite` in 1, `src_htrans` in 2, `src_hsize` in 3, `src_hburst` in 3, `src_hprot` in 4, `src_hmastlock` in 1, `src_hwdata` in W_DATA: upstream address/data phase.
- `src_hrdata` out W_DATA: read data to the crossbar.
- `src_hexcl` in 1: transfer is exclusive.
- `src_hmaster` in 8: master ID.
- `src_hexokay` out 1: exclusive success, valid in the data phase.
- `dst_hready` out 1, `dst_hready_resp` in 1, `dst_hresp` in 1: downstream handshake.
- `dst_haddr` out W_ADDR, `dst_hwrite` out 1, `dst_htrans` out 2, `dst_hsize` out 3, `dst_hburst` out 3, `dst_hprot` out 4, `dst_hmastlock` out 1, `dst_hwdata` out W_DATA: downstream address/data phase.
- `dst_hrdata` in W_DATA: downstream read data.

## Operation
- **Accept condition.** Address phase accepted when `src_hready && src_htrans[1]`.
- **Pass-through.** All address-phase signals pass combinationally to `dst_*`. The one exception is `dst_htrans`, which is forced to 2'b00 for a failing exclusive write. `dst_hready = src_hready`. `dst_hwdata = src_hwdata`.
- **Reservation table.** Per ID: `resv_valid` and `resv_addr[W_ADDR-1:GRANULE_BITS]`. Cleared by reset only; there is no timeout.
- **Exclusive read** (hexcl, !hwrite, ID < N_MASTERS):
  - Sets `resv_valid[ID]=1` and `resv_addr[ID]=granule`; replaces any older reservation for that ID.
  - Data phase `hexokay=1`.
- **Exclusive write, pass case** (ID < N_MASTERS, `resv_valid[ID]` set, address matches):
  - Forwarded to `dst`.
  - Every entry (all IDs) whose address matches the granule is cleared.
  - Data phase `hexokay=1`.
- **Exclusive write, fail case:**
  - Not forwarded (`dst_htrans=IDLE`).
  - Writer's own entry is cleared.
  - Monitor answers itself: `src_hready_resp=1`, `src_hresp=0`, `hexokay=0`, `src_hrdata=0`.
- **Non-exclusive write** to a granule: clears every matching entry (including the writer's own). It is always forwarded.
- **Non-exclusive read:** no table effect.
- **Out-of-range ID.** ID >= N_MASTERS with hexcl: a read is forwarded with `hexokay=0` and no reservation is set; a write fails as above.
- **Data-phase registers.** Loaded on accept: `dph_excl`, `dph_ok`, `dph_supp`.
  - Cleared when `src_hready` is high and no new transfer is accepted.
  - Held while `src_hready=0`.
- **Response muxing:**
  - `src_hready_resp = dph_supp ? 1 : dst_hready_resp`.
  - `src_hresp = dph_supp ? 0 : dst_hresp`.
  - `src_hexokay = dph_excl & dph_ok & !src_hresp`.
- **Ordering of table updates.** Updates occur at the accept edge and use pre-update table state. When several rules apply in one cycle, set and clear are resolved in the order above; each accept updates only the entries its rule names.

## Timing
- Zero added latency. The address path is combinational; the data-phase flags are one register stage.
- **Reset values:**
  - All `resv_valid=0`; `dph_excl=dph_ok=dph_supp=0`.
  - `src_hexokay=0`.
  - `src_hready_resp`/`src_hresp`/`src_hrdata` follow `dst_*`.
  - `dst_*` address outputs follow `src_*`.
- **Suppressed write data phase.** It completes in 1 cycle regardless of `dst_hready_resp`. This is legal because `dst` sees an IDLE data phase.
- **Wait states.** With `dst_hready_resp=0`, the flags hold; `hexokay` stays valid across wait states.
- **Error response.** `dst_hresp=1` forces `hexokay=0`. A table update already made at accept is not reverted.
- **Reset mid-transfer.** Asserting `rst_n` low mid-transfer clears the table and flags immediately (async).

## Test plan
- ID0 exclusive read 0x100, then ID0 exclusive write 0x100 -> write forwarded, `hexokay=1`, `resv_valid[0]=0`.
- ID0 exclusive read 0x100, ID1 plain write 0x102 (same granule), ID0 exclusive write 0x100 -> `dst_htrans=00`, `src_hready_resp=1` same cycle, `hexokay=0`, memory unchanged.
- ID0 and ID1 exclusive read 0x200; ID1 exclusive write 0x200 ok; ID0 exclusive write 0x200 -> fails.
- ID0 exclusive read 0x100, ID0 exclusive write 0x104 -> fails, `resv_valid[0]` cleared; retry at 0x100 -> fails.
- Exclusive write pass with `dst_hready_resp` low 3 cycles -> `hexokay=1` held all 4 data cycles; with `dst_hresp=1` -> `hexokay=0`.
- `src_hmaster=5` with N_MASTERS=2, exclusive read then write -> read `hexokay=0`, write suppressed; reset mid-stream -> all `resv_valid=0`.
